// File: rtl/bcd_addsub_seq.sv
// bcd_addsub_seq: multi-cycle packed-BCD adder/subtractor.
//
// Processes DIGITS_PER_CYCLE digits per clock, least significant digit first.
// Subtraction is A + nines(B) + ~borrow_in, so one decimal ripple serves both modes.
// In subtract mode the carry-out doubles as "no borrow".
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   s_valid    operand valid
//   s_ready    operand accept (high only in IDLE and not in reset)
//   s_a, s_b   packed BCD operands, digit 0 at bits [3:0]
//   s_cin      add: carry-in, sub: borrow-in
//   s_sub      0 = A+B+cin, 1 = A-B-cin
//   m_valid    result valid, held until m_ready
//   m_ready    consumer accepts the result
//   m_sum      packed BCD result
//   m_cout     add: carry-out, sub: 1 = no borrow
//   m_invalid  some digit of A or B was greater than 9
module bcd_addsub_seq #(
  parameter int unsigned DIGITS           = 100,
  parameter int unsigned DIGITS_PER_CYCLE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [4*DIGITS-1:0]   s_a,
  input  logic [4*DIGITS-1:0]   s_b,
  input  logic                  s_cin,
  input  logic                  s_sub,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [4*DIGITS-1:0]   m_sum,
  output logic                  m_cout,
  output logic                  m_invalid
);

  localparam int unsigned STEPS  = DIGITS / DIGITS_PER_CYCLE;
  localparam int unsigned Width  = 4 * DIGITS;
  localparam int unsigned SliceW = 4 * DIGITS_PER_CYCLE;
  localparam int unsigned StepW  = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (DIGITS < 1 || DIGITS_PER_CYCLE < 1 || (DIGITS % DIGITS_PER_CYCLE) != 0) begin : g_bad_param
    $error("bcd_addsub_seq: DIGITS_PER_CYCLE must be >= 1 and divide DIGITS exactly");
  end

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e                        state_q, state_d;
  logic [StepW-1:0]              step_q, step_d;
  logic [STEPS-1:0][SliceW-1:0]  a_q, a_d;
  // Holds B in add mode and its nine's complement in subtract mode.
  logic [STEPS-1:0][SliceW-1:0]  b_q, b_d;
  logic [STEPS-1:0][SliceW-1:0]  sum_q, sum_d;
  logic                          carry_q, carry_d;
  logic                          cout_q, cout_d;
  logic                          inv_q, inv_d;

  logic [Width-1:0]              b_nines;
  logic [SliceW-1:0]             a_slice, b_slice, dig_slice;
  logic                          slice_cout, slice_inv;
  logic                          last_step;

  // Nine's complement per digit, wrapping mod 16. A digit b > 9 maps to 9-b mod 16,
  // which is again > 9, so the invalid check on the stored B' also covers original B.
  always_comb begin
    b_nines = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      b_nines[4*i +: 4] = 4'd9 - s_b[4*i +: 4];
    end
  end

  // Select the slice for the current step; a compare loop keeps STEPS == 1 simple.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int s = 0; s < int'(STEPS); s++) begin
      if (StepW'(s) == step_q) begin
        a_slice = a_q[s];
        b_slice = b_q[s];
      end
    end
  end

  // Decimal ripple across the digits of one slice.
  logic [3:0] ad, bd;
  logic [4:0] t, t_adj;
  logic       c;

  always_comb begin
    c         = carry_q;
    slice_inv = 1'b0;
    dig_slice = '0;
    ad        = '0;
    bd        = '0;
    t         = '0;
    t_adj     = '0;
    for (int j = 0; j < int'(DIGITS_PER_CYCLE); j++) begin
      ad    = a_slice[4*j +: 4];
      bd    = b_slice[4*j +: 4];
      t     = {1'b0, ad} + {1'b0, bd} + {4'b0000, c};
      t_adj = t + 5'd6;
      if (t > 5'd9) begin
        dig_slice[4*j +: 4] = t_adj[3:0];
        c                   = 1'b1;
      end else begin
        dig_slice[4*j +: 4] = t[3:0];
        c                   = 1'b0;
      end
      if (ad > 4'd9 || bd > 4'd9) begin
        slice_inv = 1'b1;
      end
    end
    slice_cout = c;
  end

  assign last_step = (step_q == StepW'(STEPS - 1));

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    inv_d   = inv_q;
    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          a_d     = s_a;
          b_d     = s_sub ? b_nines : s_b;
          carry_d = s_sub ? ~s_cin : s_cin;
          inv_d   = 1'b0;
          step_d  = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        for (int s = 0; s < int'(STEPS); s++) begin
          if (StepW'(s) == step_q) begin
            sum_d[s] = dig_slice;
          end
        end
        carry_d = slice_cout;
        inv_d   = inv_q | slice_inv;
        if (last_step) begin
          cout_d  = slice_cout;
          state_d = StDone;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      StDone: begin
        if (m_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      inv_q   <= inv_d;
    end
  end

  assign s_ready   = (state_q == StIdle) && !rst;
  assign m_valid   = (state_q == StDone);
  assign m_sum     = sum_q;
  assign m_cout    = cout_q;
  assign m_invalid = inv_q;

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Bench for bcd_addsub_seq: four instances (4/2, 4/1, 4/4 and 100/4 digits per cycle)
// share a scoreboard queue; a negedge monitor pops and checks every delivered result.
module tb_bcd_addsub_seq;

  localparam int NInst = 4;
  localparam int MaxW  = 400;

  function automatic int dig_of(input int g);
    return (g == 3) ? 100 : 4;
  endfunction

  function automatic int dpc_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int steps_of(input int g);
    return dig_of(g) / dpc_of(g);
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            s_valid [NInst];
  logic            s_ready [NInst];
  logic            s_cin   [NInst];
  logic            s_sub   [NInst];
  logic            m_valid [NInst];
  logic            m_ready [NInst];
  logic            m_cout  [NInst];
  logic            m_inv   [NInst];
  logic [MaxW-1:0] s_a     [NInst];
  logic [MaxW-1:0] s_b     [NInst];
  logic [MaxW-1:0] m_sum   [NInst];

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    localparam int D = dig_of(g);
    localparam int P = dpc_of(g);
    logic [4*D-1:0] sum_l;
    logic           rdy_l, vld_l, cout_l, inv_l;

    bcd_addsub_seq #(
      .DIGITS           (D),
      .DIGITS_PER_CYCLE (P)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid[g]),
      .s_ready   (rdy_l),
      .s_a       (s_a[g][4*D-1:0]),
      .s_b       (s_b[g][4*D-1:0]),
      .s_cin     (s_cin[g]),
      .s_sub     (s_sub[g]),
      .m_valid   (vld_l),
      .m_ready   (m_ready[g]),
      .m_sum     (sum_l),
      .m_cout    (cout_l),
      .m_invalid (inv_l)
    );

    assign s_ready[g] = rdy_l;
    assign m_valid[g] = vld_l;
    assign m_cout[g]  = cout_l;
    assign m_inv[g]   = inv_l;
    assign m_sum[g]   = MaxW'(sum_l);
  end

  typedef struct {
    int              inst;
    logic [MaxW-1:0] sum;
    logic            cout;
    logic            inv;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [MaxW-1:0] act,
                       input logic [MaxW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: schoolbook decimal arithmetic on digit values.
  task automatic ref_model(input int nd, input logic [MaxW-1:0] a, input logic [MaxW-1:0] b,
                           input logic cin, input logic sub,
                           output logic [MaxW-1:0] s, output logic cout);
    int cy;
    int v;
    s  = '0;
    cy = int'(cin);
    for (int i = 0; i < nd; i++) begin
      if (!sub) begin
        v  = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + cy;
        cy = v / 10;
        v  = v % 10;
      end else begin
        v  = int'(a[4*i +: 4]) - int'(b[4*i +: 4]) - cy;
        cy = (v < 0) ? 1 : 0;
        if (v < 0) v += 10;
      end
      s[4*i +: 4] = 4'(v);
    end
    cout = sub ? (cy == 0) : (cy != 0);
  endtask

  function automatic logic [MaxW-1:0] rand_bcd(input int nd);
    logic [MaxW-1:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Monitor: one pop per delivered result.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < NInst; g++) begin
      if (!rst && m_valid[g] && m_ready[g]) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: inst %0d emitted %0h, expected no result", g,
                   m_sum[g]);
        end else begin
          e = exp_q.pop_front();
          check("result_inst", MaxW'(g), MaxW'(e.inst));
          check("m_sum", m_sum[g], e.sum);
          check("m_cout", MaxW'(m_cout[g]), MaxW'(e.cout));
          check("m_invalid", MaxW'(m_inv[g]), MaxW'(e.inv));
        end
      end
    end
  end

  task automatic wait_ready(input int g);
    int n;
    n = 0;
    while (!s_ready[g] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready[g]) check("s_ready_timeout", MaxW'(s_ready[g]), MaxW'(1));
  endtask

  // Issue one operation, push its expectation and check the latency to m_valid.
  task automatic issue(input int g, input logic [MaxW-1:0] a, input logic [MaxW-1:0] b,
                       input logic cin, input logic sub, input logic [MaxW-1:0] es,
                       input logic ec, input logic ei);
    exp_t e;
    int   lat;
    wait_ready(g);
    e.inst = g;
    e.sum  = es;
    e.cout = ec;
    e.inv  = ei;
    exp_q.push_back(e);
    s_a[g]     = a;
    s_b[g]     = b;
    s_cin[g]   = cin;
    s_sub[g]   = sub;
    s_valid[g] = 1'b1;
    @(posedge clk);
    #1;
    s_valid[g] = 1'b0;
    // Operands are captured; changing them now must not affect the result.
    s_a[g]   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    s_b[g]   = ~s_a[g];
    s_cin[g] = ~cin;
    s_sub[g] = ~sub;
    lat = 0;
    while (!m_valid[g] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", MaxW'(lat), MaxW'(steps_of(g)));
  endtask

  task automatic issue_rand(input int g);
    logic [MaxW-1:0] a, b, es;
    logic            cin, sub, ec;
    a   = rand_bcd(dig_of(g));
    b   = rand_bcd(dig_of(g));
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
    ref_model(dig_of(g), a, b, cin, sub, es, ec);
    issue(g, a, b, cin, sub, es, ec, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MaxW-1:0] a, b, es;
    logic            ec;
    int              n;

    for (int g = 0; g < NInst; g++) begin
      s_valid[g] = 1'b0;
      m_ready[g] = 1'b1;
      s_a[g]     = '0;
      s_b[g]     = '0;
      s_cin[g]   = 1'b0;
      s_sub[g]   = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NInst; g++) begin
      check("s_ready_in_reset", MaxW'(s_ready[g]), MaxW'(0));
      check("m_valid_in_reset", MaxW'(m_valid[g]), MaxW'(0));
    end
    rst = 1'b0;
    #1;
    for (int g = 0; g < NInst; g++) begin
      check("s_ready_after_reset", MaxW'(s_ready[g]), MaxW'(1));
      check("m_sum_after_reset", m_sum[g], '0);
      check("m_cout_after_reset", MaxW'(m_cout[g]), MaxW'(0));
    end

    // Directed vectors: inst, A, B, cin, sub, sum, cout, invalid
    issue(0, 'h1234, 'h5678, 1'b0, 1'b0, 'h6912, 1'b0, 1'b0);
    issue(1, 'h9999, 'h0000, 1'b1, 1'b0, 'h0000, 1'b1, 1'b0);
    issue(2, 'h0100, 'h0001, 1'b0, 1'b1, 'h0099, 1'b1, 1'b0);
    issue(2, 'h0001, 'h0002, 1'b0, 1'b1, 'h9999, 1'b0, 1'b0);
    issue(0, 'h00A0, 'h0001, 1'b0, 1'b0, 'h0101, 1'b0, 1'b1);
    issue(0, 'h0005, 'h0005, 1'b0, 1'b0, 'h0010, 1'b0, 1'b0);
    issue(1, 'h0000, 'h00B0, 1'b0, 1'b1, 'h0050, 1'b1, 1'b1);
    issue(1, 'h0000, 'h0000, 1'b1, 1'b1, 'h9999, 1'b0, 1'b0);

    // Backpressure: result held, no new operand accepted.
    a = rand_bcd(4);
    b = rand_bcd(4);
    ref_model(4, a, b, 1'b1, 1'b0, es, ec);
    m_ready[0] = 1'b0;
    issue(0, a, b, 1'b1, 1'b0, es, ec, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_m_valid", MaxW'(m_valid[0]), MaxW'(1));
      check("bp_m_sum", m_sum[0], es);
      check("bp_m_cout", MaxW'(m_cout[0]), MaxW'(ec));
      check("bp_s_ready", MaxW'(s_ready[0]), MaxW'(0));
    end
    m_ready[0] = 1'b1;

    // Random traffic on the small instances
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 8; k++) issue_rand(g);
    end

    // 100-digit instance: one result, then reset at step 10.
    issue_rand(3);
    wait_ready(3);
    s_a[3]     = rand_bcd(100);
    s_b[3]     = rand_bcd(100);
    s_sub[3]   = 1'b0;
    s_cin[3]   = 1'b1;
    s_valid[3] = 1'b1;
    @(posedge clk);
    #1;
    s_valid[3] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("s_ready_mid_reset", MaxW'(s_ready[3]), MaxW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_m_valid", MaxW'(m_valid[3]), MaxW'(0));
    check("abort_m_sum", m_sum[3], '0);
    check("abort_m_invalid", MaxW'(m_inv[3]), MaxW'(0));
    check("abort_s_ready", MaxW'(s_ready[3]), MaxW'(1));
    // Any result emitted here would be caught by the monitor as unexpected.
    repeat (30) @(negedge clk);

    for (int k = 0; k < 6; k++) issue_rand(3);

    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", MaxW'(exp_q.size()), MaxW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_addsub_seq.md
Name: bcd_addsub_seq

Overview:
Parametrised, multi-cycle BCD adder/subtractor operating on packed-BCD operands of DIGITS decimal digits, processing DIGITS_PER_CYCLE digits per clock from the least significant digit. It generalises the combinational BCD ripple-carry adder by adding a subtract mode, a flag for invalid BCD input digits, and valid/ready handshakes on both the input and result sides, trading latency for area. It sits between a BCD operand source (CSR or stream) and a result consumer.

Parameters:
DIGITS, 100, number of BCD digits per operand; must be >= 1.
DIGITS_PER_CYCLE, 4, digits processed per clock; must divide DIGITS exactly, otherwise elaboration fails.
STEPS (localparam), DIGITS/DIGITS_PER_CYCLE, number of compute cycles per operation.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst  input  1  synchronous, active-high reset.
s_valid  input  1  operand valid.
s_ready  output  1  block can accept operands.
s_a  input  4*DIGITS  operand A, packed BCD, digit 0 at bits [3:0].
s_b  input  4*DIGITS  operand B, packed BCD.
s_cin  input  1  add: carry-in; sub: borrow-in.
s_sub  input  1  0 = A+B+cin; 1 = A-B-cin.
m_valid  output  1  result valid.
m_ready  input  1  consumer accepts the result.
m_sum  output  4*DIGITS  result digits, packed BCD.
m_cout  output  1  add: carry-out; sub: 1 = no borrow (A >= B+cin), 0 = borrow (m_sum is the 10's complement).
m_invalid  output  1  at least one digit of s_a or s_b was > 9.

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset puts the FSM in IDLE. Reset values: m_valid=0, m_sum=0, m_cout=0, m_invalid=0, step counter=0. s_ready=0 while rst=1.
- IDLE: s_ready=1. When s_valid&&s_ready, register A, B' and c0, clear the invalid flag, and go to BUSY with step=0.
  - B' = B in add mode. In sub mode B' = nine's complement of each digit, (9-b) mod 16.
  - c0 = s_cin in add mode. In sub mode c0 = ~s_cin.
- BUSY: on each cycle, process digits k = step*DPC .. step*DPC+DPC-1 as a ripple from low to high.
  - Compute t = a_k + b'_k + c (5-bit).
  - If t > 9: digit = (t+6)[3:0] and c = 1. Otherwise digit = t[3:0] and c = 0.
  - Write the digit into the m_sum register slice, and register c for the next step.
  - OR in invalid if any a_k > 9 or original b_k > 9. Invalid digits still follow the rule above, so the result is deterministic.
  - When step = STEPS-1, m_cout takes the final carry, m_valid goes to 1, and the FSM goes to DONE. Otherwise step increments.
- Latency: with the input handshake on edge N, m_valid rises after edge N+STEPS. For STEPS=1, m_valid is high in the cycle after acceptance.
- DONE: m_valid=1. m_sum, m_cout and m_invalid stay stable until m_valid&&m_ready. On that edge m_valid goes to 0 and the FSM goes to IDLE, so s_ready=1 the following cycle.
  - Throughput is one operation per STEPS+2 cycles.
  - No new operand is accepted while in BUSY or DONE.
- m_sum holds intermediate digits while BUSY; it is meaningful only while m_valid=1.
- Inputs s_a, s_b, s_sub and s_cin are sampled only on the accepting edge; later changes to them have no effect.
- Reset mid-operation (BUSY or DONE) abandons the operation, restores all reset values, and returns to IDLE. No result is emitted.
- m_ready asserted while m_valid=0 is ignored.

Test Plan:
- DIGITS=4, DPC=2, add: A=0x1234, B=0x5678, cin=0 -> m_sum=0x6912, m_cout=0, m_invalid=0. m_valid rises exactly 2 cycles after the handshake.
- Add with overflow, DIGITS=4, DPC=1: A=0x9999, B=0x0000, cin=1 -> m_sum=0x0000, m_cout=1. Latency is 4 cycles.
- Sub, DIGITS=4, DPC=4: A=0x0100, B=0x0001, cin=0 -> m_sum=0x0099, m_cout=1. Sub with A=0x0001, B=0x0002, cin=0 -> m_sum=0x9999, m_cout=0.
- Invalid digit, DIGITS=4: A=0x00A0, B=0x0001, add -> m_invalid=1 and m_sum=0x0101 per the correction rule. A following valid operation -> m_invalid=0.
- Backpressure: hold m_ready=0 for 5 cycles after m_valid -> outputs stable and s_ready=0 throughout. Change s_a during BUSY -> result unaffected.
- Reset in BUSY (DIGITS=100, DPC=4, step=10) -> next cycle m_valid=0, m_sum=0, s_ready=1 after rst deasserts. Then a full 100-digit random sum checked against the reference model with latency 25.
